// File: rtl/aud_i2s_recorder_if.sv
// SRAM write port of the I2S recorder: valid/ready with address and sample data.
interface aud_i2s_recorder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/aud_i2s_recorder.sv
// I2S ADC capture into SRAM, one sample per LRCK frame, with start/pause/stop control.
// Optional REC_MONO_MIX_EN: writes (L+R)>>>1 instead of the left channel alone.
//
// state   | meaning
// IDLE    | stopped, waiting for start
// ARM     | waiting for an LRCK falling edge to align to a frame
// CAPTURE | shifting channel bits, issuing one write per frame
// PAUSED  | halted, address and length kept for resume
module aud_i2s_recorder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_stop,
  input  logic               i_aud_bclk,
  input  logic               i_aud_lrck,
  input  logic               i_aud_adcdat,
  aud_i2s_recorder_if.master wr,
  output logic [ADDR_W-1:0]  o_rec_len,
  output logic [1:0]         o_state,
  output logic               o_full,
  output logic               o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_PAUSED  = 2'd3
  } state_t;

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lrck_last_q, lrck_last_d;
  logic [DATA_W-2:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   shifting_q, shifting_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]      rec_len_q, rec_len_d;
  logic                   full_q, full_d;
  logic                   overrun_q, overrun_d;
`ifdef REC_MONO_MIX_EN
  logic                   chan_q, chan_d;
  logic                   left_have_q, left_have_d;
  logic [DATA_W-1:0]      left_q, left_d;
  logic [DATA_W:0]        mix_sum;
  logic                   lrck_rise;
`endif

  logic              bclk_s, lrck_s, dat_s;
  logic              bclk_rise, lrck_fall;
  logic              accept, hit_full;
  logic              sample_done;
  logic [DATA_W-1:0] sample_val;
  logic [DATA_W-1:0] word;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrck_fall = bclk_rise & lrck_last_q & ~lrck_s;
`ifdef REC_MONO_MIX_EN
  assign lrck_rise = bclk_rise & ~lrck_last_q & lrck_s;
`endif
  assign word      = {shift_q, dat_s};

  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i_aud_bclk};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], i_aud_lrck};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], i_aud_adcdat};
    bclk_prev_d = bclk_s;
    lrck_last_d = lrck_last_q;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    shifting_d  = shifting_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rec_len_d   = rec_len_q;
    full_d      = full_q;
    overrun_d   = overrun_q;
    accept      = wr_valid_q & wr.wr_ready;
    hit_full    = 1'b0;
    sample_done = 1'b0;
    sample_val  = '0;
`ifdef REC_MONO_MIX_EN
    chan_d      = chan_q;
    left_have_d = left_have_q;
    left_d      = left_q;
    mix_sum     = '0;
`endif

    if (bclk_rise) lrck_last_d = lrck_s;

    // Bit capture; a channel completes on its LSB, the next one may start on the same edge.
    if (state_q == S_CAPTURE && bclk_rise) begin
      if (shifting_q) begin
        shift_d   = word[DATA_W-2:0];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          shifting_d = 1'b0;
`ifdef REC_MONO_MIX_EN
          if (chan_q) begin
            if (left_have_q) begin
              mix_sum     = {left_q[DATA_W-1], left_q} + {word[DATA_W-1], word};
              sample_done = 1'b1;
              sample_val  = mix_sum[DATA_W:1];
            end
            left_have_d = 1'b0;
          end else begin
            left_d      = word;
            left_have_d = 1'b1;
          end
`else
          sample_done = 1'b1;
          sample_val  = word;
`endif
        end
      end
      if (lrck_fall) begin
        shifting_d  = 1'b1;
        bit_cnt_d   = '0;
`ifdef REC_MONO_MIX_EN
        chan_d      = 1'b0;
        left_have_d = 1'b0;
      end else if (lrck_rise && left_have_d) begin
        shifting_d  = 1'b1;
        bit_cnt_d   = '0;
        chan_d      = 1'b1;
`endif
      end
    end

    if (state_q == S_ARM && lrck_fall) begin
      state_d     = S_CAPTURE;
      shifting_d  = 1'b1;
      bit_cnt_d   = '0;
`ifdef REC_MONO_MIX_EN
      chan_d      = 1'b0;
      left_have_d = 1'b0;
`endif
    end

    // The address never wraps; the final accepted write ends the recording.
    if (accept) begin
      wr_valid_d = 1'b0;
      if (rec_len_q != ADDR_MAX) rec_len_d = rec_len_q + ADDR_W'(1);
      if (wr_addr_q == ADDR_MAX) begin
        full_d   = 1'b1;
        hit_full = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end

    if (sample_done) begin
      if (wr_valid_q && !accept) begin
        overrun_d = 1'b1;
      end else if (!hit_full) begin
        wr_valid_d = 1'b1;
        wr_data_d  = sample_val;
      end
    end

    if (i_stop && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      shifting_d = 1'b0;
    end else if (i_pause && (state_q == S_ARM || state_q == S_CAPTURE)) begin
      state_d    = S_PAUSED;
      shifting_d = 1'b0;
    end else if (i_start && state_q == S_IDLE) begin
      state_d    = S_ARM;
      wr_addr_d  = '0;
      rec_len_d  = '0;
      full_d     = 1'b0;
      overrun_d  = 1'b0;
    end else if (i_start && state_q == S_PAUSED) begin
      state_d    = S_ARM;
    end
    if (hit_full) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_last_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      shifting_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rec_len_q   <= '0;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef REC_MONO_MIX_EN
      chan_q      <= 1'b0;
      left_have_q <= 1'b0;
      left_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      dat_sync_q  <= dat_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_last_q <= lrck_last_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      shifting_q  <= shifting_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rec_len_q   <= rec_len_d;
      full_q      <= full_d;
      overrun_q   <= overrun_d;
`ifdef REC_MONO_MIX_EN
      chan_q      <= chan_d;
      left_have_q <= left_have_d;
      left_q      <= left_d;
`endif
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign o_rec_len   = rec_len_q;
  assign o_state     = state_q;
  assign o_full      = full_q;
  assign o_overrun   = overrun_q;

endmodule
